// File: rtl/fft_tw_sched.sv
// fft_tw_sched -- twiddle-address sequencer for one radix-2 FFT stage.
//
// Walks the 2^ADDR_W-entry twiddle ROM address from 0 to the top entry,
// holding each address for HOLD accepted butterfly beats. A frame is kicked
// off by a single-cycle start pulse and only advances on din_valid beats.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   start      frame start request (single-cycle pulse)
//   din_valid  butterfly data beat present this cycle
//   tw_addr    twiddle ROM address (registered)
//   tw_valid   tw_addr is live for the current beat (RUN)
//   beat_idx   beat count within the current address (registered)
//   busy       frame in progress
//   frame_done one-cycle pulse after the last beat of a frame
//   start_err  one-cycle pulse when a start arrives mid-frame and is rejected
//
// All outputs are flops. The next-state and output-next-value logic are
// combinational; a single register process captures both.

module fft_tw_sched #(
  parameter int ADDR_W = 2,
  parameter int HOLD   = 4,
  localparam int BW    = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              tw_valid,
  output logic [BW-1:0]     beat_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              start_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [BW-1:0]     BEAT_MAX = BW'(HOLD - 1);

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_n;
  logic [BW-1:0]     beat_n;
  logic              done_n;
  logic              err_n;
  logic              last_beat;
  logic              addr_step;

  // Final accepted beat of the frame: top address, top beat, data present.
  assign last_beat = (state == RUN) && din_valid &&
                     (tw_addr == ADDR_MAX) && (beat_idx == BEAT_MAX);

  // Current address has received its HOLD beats; move to the next entry.
  assign addr_step = (beat_idx == BEAT_MAX);

  // ---------------------------------------------------------------------
  // State register (also captures the registered outputs)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      tw_addr    <= '0;
      beat_idx   <= '0;
      tw_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      state      <= state_n;
      tw_addr    <= addr_n;
      beat_idx   <= beat_n;
      tw_valid   <= (state_n == RUN);
      busy       <= (state_n == RUN);
      frame_done <= done_n;
      start_err  <= err_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      // A start coinciding with the last beat chains straight into a new
      // frame; otherwise the frame drops back to IDLE.
      RUN:  if (last_beat) state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output next-value logic
  // ---------------------------------------------------------------------
  always_comb begin
    addr_n = tw_addr;
    beat_n = beat_idx;
    done_n = 1'b0;
    err_n  = 1'b0;
    case (state)
      IDLE: begin
        // Counters sit at zero; din_valid here is simply ignored.
        addr_n = '0;
        beat_n = '0;
      end
      RUN: begin
        if (last_beat) begin
          // Restart counters whether or not a chained frame follows.
          addr_n = '0;
          beat_n = '0;
          done_n = 1'b1;
        end else begin
          // Mid-frame start is flagged but leaves the frame untouched.
          err_n = start;
          if (din_valid) begin
            if (addr_step) begin
              beat_n = '0;
              addr_n = tw_addr + ADDR_W'(1);
            end else begin
              beat_n = beat_idx + BW'(1);
            end
          end
        end
      end
      default: begin
        addr_n = '0;
        beat_n = '0;
      end
    endcase
    // With a single beat per address the beat counter carries no state.
    if (HOLD == 1) beat_n = '0;
  end

endmodule

// File: tb/tb_fft_tw_sched.sv
// Directed bench for fft_tw_sched with ADDR_W=2, HOLD=4 (16-beat frames).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so every check sees the values registered at the preceding edge.

module tb_fft_tw_sched;

  localparam int ADDR_W = 2;
  localparam int HOLD   = 4;
  localparam int BEATS  = (1 << ADDR_W) * HOLD;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       din_valid;
  logic [1:0] tw_addr;
  logic       tw_valid;
  logic [1:0] beat_idx;
  logic       busy;
  logic       frame_done;
  logic       start_err;

  int checks   = 0;
  int failures = 0;

  fft_tw_sched #(.ADDR_W(ADDR_W), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .din_valid (din_valid),
    .tw_addr   (tw_addr),
    .tw_valid  (tw_valid),
    .beat_idx  (beat_idx),
    .busy      (busy),
    .frame_done(frame_done),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, clock, then settle past the edge.
  task automatic cyc(input logic st, input logic dv);
    start     = st;
    din_valid = dv;
    @(posedge clk);
    #1;
    start     = 1'b0;
    din_valid = 1'b0;
  endtask

  // Check the counters expected for beat i of a running frame.
  task automatic chk_beat(input string tag, input int i);
    chk({tag, "_addr"},  tw_addr,  i / HOLD);
    chk({tag, "_beat"},  beat_idx, i % HOLD);
    chk({tag, "_valid"}, tw_valid, 1);
    chk({tag, "_busy"},  busy,     1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"},  tw_addr,    0);
    chk({tag, "_beat"},  beat_idx,   0);
    chk({tag, "_valid"}, tw_valid,   0);
    chk({tag, "_busy"},  busy,       0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_err"},   start_err,  0);
  endtask

  int done_cnt;

  initial begin
    rstn = 1'b0; start = 1'b0; din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_idle("reset");
    rstn = 1'b1;

    // din_valid while idle has no effect
    cyc(0, 1);
    chk_idle("idle_dv1");
    cyc(0, 1);
    chk("idle_dv2_addr", tw_addr, 0);
    chk("idle_dv2_busy", busy, 0);

    // --- continuous frame ------------------------------------------------
    cyc(1, 0);
    chk("cont_start_done", frame_done, 0);
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("cont", i);
      chk("cont_done_low", frame_done, 0);
      cyc(0, 1);
    end
    chk("cont_done", frame_done, 1);
    chk("cont_done_busy", busy, 0);
    chk("cont_done_valid", tw_valid, 0);
    chk("cont_done_addr", tw_addr, 0);
    cyc(0, 0);
    chk("cont_done_pulse", frame_done, 0);

    // --- stalls every other cycle ---------------------------------------
    cyc(1, 0);
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("stall", i);
      cyc(0, 0);
      chk_beat("stall_hold", i);
      chk("stall_done_low", frame_done, 0);
      cyc(0, 1);
    end
    chk("stall_done", frame_done, 1);
    chk("stall_done_busy", busy, 0);

    // --- start during a frame -------------------------------------------
    cyc(1, 0);
    done_cnt = 0;
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("ovl", i);
      if (i == 6) chk("ovl_err", start_err, 1);
      else        chk("ovl_err_low", start_err, 0);
      cyc(i == 5, 1);
      if (frame_done) done_cnt++;
    end
    chk("ovl_done", frame_done, 1);
    chk("ovl_done_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0);
      if (frame_done) done_cnt++;
    end
    chk("ovl_single_done", done_cnt, 1);
    chk("ovl_err_end", start_err, 0);

    // --- back-to-back frames --------------------------------------------
    cyc(1, 0);
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("b2b_a", i);
      cyc(i == BEATS - 1, 1);
    end
    chk("b2b_done",  frame_done, 1);
    chk("b2b_busy",  busy,       1);
    chk("b2b_valid", tw_valid,   1);
    chk("b2b_addr",  tw_addr,    0);
    chk("b2b_beat",  beat_idx,   0);
    chk("b2b_err",   start_err,  0);
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("b2b_b", i);
      if (i > 0) chk("b2b_b_done_low", frame_done, 0);
      cyc(0, 1);
    end
    chk("b2b_b_done", frame_done, 1);
    chk("b2b_b_busy", busy, 0);

    // --- reset mid-frame ------------------------------------------------
    cyc(1, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1);
    chk("mid_addr", tw_addr, 2);
    chk("mid_beat", beat_idx, 1);
    rstn = 1'b0;
    cyc(0, 1);
    chk_idle("mid_rst");
    rstn = 1'b1;
    cyc(0, 1);
    chk_idle("mid_after");
    cyc(1, 0);
    for (int i = 0; i < BEATS; i++) begin
      chk_beat("rerun", i);
      chk("rerun_done_low", frame_done, 0);
      cyc(0, 1);
    end
    chk("rerun_done", frame_done, 1);
    chk("rerun_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
